// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT core datapath: coefficient/address/word widths,
// default pipeline latencies and the write-back stage state encoding.
package ntt_pkg;

   localparam int COEFF_W               = 30;
   localparam int ADDR_W                = 9;
   localparam int WORD_W                = 60;
   localparam int READ_LATENCY_DEF      = 2;
   localparam int BUTTERFLY_LATENCY_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wb_state_e;

endpackage

// File: rtl/ntt_core_writeback_if.sv
// Core-facing bundle of the write-back stage: stage control, read tracking,
// butterfly results, BRAM write ports, result stream and status.
interface ntt_core_writeback_if;
   import ntt_pkg::*;

   logic                 start;
   logic                 final_stage;
   logic                 read_valid;
   logic [ADDR_W-1:0]    read_address;
   logic [COEFF_W-1:0]   r1;
   logic [COEFF_W-1:0]   r2;
   logic [COEFF_W-1:0]   r3;
   logic [COEFF_W-1:0]   r4;
   logic                 upper_write_enable;
   logic                 lower_write_enable;
   logic [ADDR_W-1:0]    upper_write_address;
   logic [ADDR_W-1:0]    lower_write_address;
   logic [WORD_W-1:0]    upper_data_input;
   logic [WORD_W-1:0]    lower_data_input;
   logic                 out_valid;
   logic [4*COEFF_W-1:0] out_data;
   logic                 busy;
   logic                 stage_done;
   logic                 overlap_err;

   modport slave (
      input  start, final_stage, read_valid, read_address, r1, r2, r3, r4,
      output upper_write_enable, lower_write_enable,
             upper_write_address, lower_write_address,
             upper_data_input, lower_data_input,
             out_valid, out_data, busy, stage_done, overlap_err
   );

   modport master (
      output start, final_stage, read_valid, read_address, r1, r2, r3, r4,
      input  upper_write_enable, lower_write_enable,
             upper_write_address, lower_write_address,
             upper_data_input, lower_data_input,
             out_valid, out_data, busy, stage_done, overlap_err
   );

endinterface

// File: rtl/ntt_token_delay.sv
// Fixed-depth shift register of {valid, addr} tokens that mirrors the BRAM read
// plus butterfly pipeline, so bubbles come out exactly where they went in.
module ntt_token_delay
   import ntt_pkg::*;
#(
   parameter int STAGES = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr
);

   logic              valid_reg [STAGES];
   logic [ADDR_W-1:0] addr_reg  [STAGES];
   logic              valid_in  [STAGES];
   logic [ADDR_W-1:0] addr_in   [STAGES];

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_tap
         if (gi == 0) begin : g_head
            assign valid_in[gi] = in_valid;
            assign addr_in[gi]  = in_addr;
         end else begin : g_body
            assign valid_in[gi] = valid_reg[gi-1];
            assign addr_in[gi]  = addr_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            valid_reg[i] <= 1'b0;
            addr_reg[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            valid_reg[i] <= valid_in[i];
            addr_reg[i]  <= addr_in[i];
         end
      end
   end

   assign out_valid = valid_reg[STAGES-1];
   assign out_addr  = addr_reg[STAGES-1];

endmodule

// File: rtl/ntt_core_writeback.sv
// NTT core write-back stage: tracks issued reads through the read+butterfly latency,
// then writes packed results back to the BRAM pair or streams them on the final stage.
module ntt_core_writeback
   import ntt_pkg::*;
#(
   parameter int READ_LATENCY      = READ_LATENCY_DEF,
   parameter int BUTTERFLY_LATENCY = BUTTERFLY_LATENCY_DEF,
   parameter int DEPTH             = 512
) (
   input  logic           clk,
   input  logic           rst_n,
   ntt_core_writeback_if.slave wb
);

   localparam int         LAT     = READ_LATENCY + BUTTERFLY_LATENCY;
   localparam logic [9:0] DEPTH_C = 10'(DEPTH);
   localparam logic [9:0] LAST_C  = 10'(DEPTH - 1);

   wb_state_e            state_reg, state_next;
   logic [9:0]           issue_cnt_reg, write_cnt_reg;
   logic                 final_reg, err_reg;
   logic                 accept_start, accept_read, err_set, busy_c, done_c;
   logic                 tok_valid;
   logic [ADDR_W-1:0]    tok_addr;
   logic                 wr_en_reg, out_valid_reg;
   logic [ADDR_W-1:0]    wr_addr_reg;
   logic [WORD_W-1:0]    upper_data_reg, lower_data_reg;
   logic [4*COEFF_W-1:0] out_data_reg;

   ntt_token_delay #(.STAGES(LAT)) u_token_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (accept_read),
      .in_addr  (wb.read_address),
      .out_valid(tok_valid),
      .out_addr (tok_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (wb.start) state_next = ST_RUN;
         ST_RUN:   if (wb.read_valid && issue_cnt_reg == LAST_C) state_next = ST_DRAIN;
         ST_DRAIN: if (write_cnt_reg == DEPTH_C) state_next = ST_DONE;
         ST_DONE:  state_next = wb.start ? ST_RUN : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Reads in DONE are dropped quietly: that cycle may legitimately overlap a new start.
   always_comb begin
      accept_start = 1'b0;
      accept_read  = 1'b0;
      err_set      = 1'b0;
      busy_c       = 1'b1;
      done_c       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy_c       = 1'b0;
            accept_start = wb.start;
            err_set      = wb.read_valid;
         end
         ST_RUN: begin
            accept_read = wb.read_valid;
            err_set     = wb.start;
         end
         ST_DRAIN: err_set = wb.start | wb.read_valid;
         ST_DONE: begin
            done_c       = 1'b1;
            accept_start = wb.start;
         end
         default: busy_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt_reg <= '0;
         write_cnt_reg <= '0;
         final_reg     <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         if (accept_start) begin
            issue_cnt_reg <= '0;
            write_cnt_reg <= '0;
            final_reg     <= wb.final_stage;
         end else begin
            if (accept_read) issue_cnt_reg <= issue_cnt_reg + 10'd1;
            if (tok_valid)   write_cnt_reg <= write_cnt_reg + 10'd1;
         end
         if (err_set) err_reg <= 1'b1;
      end
   end

   // Address/data registers only load on a real write so they hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_reg      <= 1'b0;
         out_valid_reg  <= 1'b0;
         wr_addr_reg    <= '0;
         upper_data_reg <= '0;
         lower_data_reg <= '0;
         out_data_reg   <= '0;
      end else begin
         wr_en_reg     <= tok_valid & ~final_reg;
         out_valid_reg <= tok_valid & final_reg;
         if (tok_valid && !final_reg) begin
            wr_addr_reg    <= tok_addr;
            upper_data_reg <= {wb.r3, wb.r1};
            lower_data_reg <= {wb.r4, wb.r2};
         end
         if (tok_valid && final_reg) out_data_reg <= {wb.r4, wb.r3, wb.r2, wb.r1};
      end
   end

   assign wb.upper_write_enable  = wr_en_reg;
   assign wb.lower_write_enable  = wr_en_reg;
   assign wb.upper_write_address = wr_addr_reg;
   assign wb.lower_write_address = wr_addr_reg;
   assign wb.upper_data_input    = upper_data_reg;
   assign wb.lower_data_input    = lower_data_reg;
   assign wb.out_valid           = out_valid_reg;
   assign wb.out_data            = out_data_reg;
   assign wb.busy                = busy_c;
   assign wb.stage_done          = done_c;
   assign wb.overlap_err         = err_reg;

endmodule

// File: tb/tb_ntt_core_writeback.sv
// Directed+random bench for ntt_core_writeback: a cycle-indexed schedule of expected
// writes/beats derived from issue times, checked every cycle with immediate assertions.
module tb_ntt_core_writeback;
   import ntt_pkg::*;

   localparam int LAT   = 7;
   localparam int LAT2  = 4;
   localparam int DEPTH = 512;
   localparam int NCYC  = 8192;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ntt_core_writeback_if wb();
   ntt_core_writeback_if wb2();

   ntt_core_writeback #(.READ_LATENCY(2), .BUTTERFLY_LATENCY(5), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wb(wb)
   );
   ntt_core_writeback #(.READ_LATENCY(1), .BUTTERFLY_LATENCY(3), .DEPTH(DEPTH)) dut2 (
      .clk(clk), .rst_n(rst_n), .wb(wb2)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit           sch_v [NCYC];
   bit           sch_f [NCYC];
   logic [8:0]   sch_a [NCYC];
   bit           sch2  [NCYC];
   logic [119:0] r_hist[NCYC];
   int           addr_q[NCYC];

   bit           m_active, m_final, m_err, pat_mode;
   int           m_issued, m_done_at;
   logic [8:0]   e_addr;
   logic [59:0]  e_udata, e_ldata;
   logic [119:0] e_out;
   int           dut_wr, dut_beats;

   task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_zero();
      chk("rst_uwe", wb.upper_write_enable, 0);
      chk("rst_lwe", wb.lower_write_enable, 0);
      chk("rst_uaddr", wb.upper_write_address, 0);
      chk("rst_laddr", wb.lower_write_address, 0);
      chk("rst_udata", wb.upper_data_input, 0);
      chk("rst_ldata", wb.lower_data_input, 0);
      chk("rst_ovalid", wb.out_valid, 0);
      chk("rst_odata", wb.out_data, 0);
      chk("rst_busy", wb.busy, 0);
      chk("rst_done", wb.stage_done, 0);
      chk("rst_err", wb.overlap_err, 0);
   endtask

   task automatic check_cycle();
      bit ev, sv;
      ev = sch_v[cyc] && !sch_f[cyc];
      sv = sch_v[cyc] && sch_f[cyc];
      if (ev) begin
         e_addr  = sch_a[cyc];
         e_udata = {r_hist[cyc-1][89:60], r_hist[cyc-1][29:0]};
         e_ldata = {r_hist[cyc-1][119:90], r_hist[cyc-1][59:30]};
      end
      if (sv) e_out = r_hist[cyc-1];
      if (wb.upper_write_enable === 1'b1) dut_wr++;
      if (wb.out_valid === 1'b1) dut_beats++;
      chk("upper_we", wb.upper_write_enable, ev);
      chk("lower_we", wb.lower_write_enable, ev);
      chk("upper_addr", wb.upper_write_address, e_addr);
      chk("lower_addr", wb.lower_write_address, e_addr);
      chk("upper_data", wb.upper_data_input, e_udata);
      chk("lower_data", wb.lower_data_input, e_ldata);
      chk("out_valid", wb.out_valid, sv);
      chk("out_data", wb.out_data, e_out);
      chk("busy", wb.busy, m_active);
      chk("stage_done", wb.stage_done, cyc == m_done_at);
      chk("overlap_err", wb.overlap_err, m_err);
      chk("sweep_we", wb2.upper_write_enable, sch2[cyc]);
      if (pat_mode && ev && e_addr == 9'd5) begin
         chk("addr5_upper", wb.upper_data_input, {30'd2005, 30'd5});
         chk("addr5_lower", wb.lower_data_input, {30'd3005, 30'd1005});
      end
   endtask

   // Advance one clock: update the model for the inputs of this cycle, then check outputs.
   task automatic tick();
      bit acc_start;
      r_hist[cyc] = {wb.r4, wb.r3, wb.r2, wb.r1};
      acc_start = rst_n && wb.start && (!m_active || cyc == m_done_at);
      if (rst_n && wb.start && !acc_start) m_err = 1'b1;
      if (rst_n && wb.read_valid) begin
         if (m_active && m_issued < DEPTH) begin
            sch_v[cyc+LAT+1] = 1'b1;
            sch_f[cyc+LAT+1] = m_final;
            sch_a[cyc+LAT+1] = wb.read_address;
            m_issued++;
            if (m_issued == DEPTH) m_done_at = cyc + LAT + 2;
         end else if (cyc != m_done_at) begin
            m_err = 1'b1;
         end
      end
      if (rst_n && wb2.read_valid) sch2[cyc+LAT2+1] = 1'b1;
      if (acc_start) begin
         m_active  = 1'b1;
         m_issued  = 0;
         m_final   = wb.final_stage;
         m_done_at = -1;
      end else if (cyc == m_done_at) begin
         m_active = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      check_cycle();
   endtask

   task automatic drive(input bit s, input bit f, input bit rv, input logic [8:0] a,
                        input bit s2, input bit rv2);
      int pa;
      wb.start        = s;
      wb.final_stage  = f;
      wb.read_valid   = rv;
      wb.read_address = a;
      addr_q[cyc]     = rv ? int'(a) : -1;
      if (pat_mode && cyc >= LAT && addr_q[cyc-LAT] >= 0) begin
         pa    = addr_q[cyc-LAT];
         wb.r1 = 30'(pa);
         wb.r2 = 30'(pa + 1000);
         wb.r3 = 30'(pa + 2000);
         wb.r4 = 30'(pa + 3000);
      end else begin
         wb.r1 = 30'($urandom);
         wb.r2 = 30'($urandom);
         wb.r3 = 30'($urandom);
         wb.r4 = 30'($urandom);
      end
      wb2.start        = s2;
      wb2.read_valid   = rv2;
      wb2.read_address = a;
      tick();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 4 * LAT + 8 && m_active; k++) idle();
      chk("drain_timeout", m_active, 1'b0);
      idle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_zero();
      for (int i = cyc; i < NCYC; i++) begin
         sch_v[i] = 1'b0;
         sch2[i]  = 1'b0;
      end
      m_active = 1'b0; m_err = 1'b0; m_done_at = -1; m_issued = 0;
      e_addr = '0; e_udata = '0; e_ldata = '0; e_out = '0;
      idle();
      idle();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NCYC; i++) addr_q[i] = -1;
      m_done_at = -1;
      e_addr = '0; e_udata = '0; e_ldata = '0; e_out = '0;
      wb.start = 0; wb.final_stage = 0; wb.read_valid = 0; wb.read_address = '0;
      wb.r1 = '0; wb.r2 = '0; wb.r3 = '0; wb.r4 = '0;
      wb2.start = 0; wb2.final_stage = 0; wb2.read_valid = 0; wb2.read_address = '0;
      wb2.r1 = '0; wb2.r2 = '0; wb2.r3 = '0; wb2.r4 = '0;
      #1;
      check_zero();
      idle();
      rst_n = 1'b1;
      idle();

      // Back-to-back write-back stage with address-derived results
      pat_mode = 1'b1;
      dut_wr = 0;
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 9'(i), 0, 0);
      drain();
      pat_mode = 1'b0;
      chk("t1_writes", dut_wr, DEPTH);

      // Reads only every other cycle
      dut_wr = 0;
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2 * DEPTH; i++) drive(0, 0, i[0], 9'($urandom), 0, 0);
      drain();
      chk("t2_writes", dut_wr, DEPTH);

      // Final stage streaming with random gaps
      dut_wr = 0; dut_beats = 0;
      drive(1, 1, 0, 0, 0, 0);
      for (int n = 0; n < DEPTH; ) begin
         bit rv;
         rv = ($urandom_range(0, 3) != 0);
         drive(0, 1, rv, 9'($urandom), 0, 0);
         if (rv) n++;
      end
      drain();
      chk("t3_beats", dut_beats, DEPTH);
      chk("t3_writes", dut_wr, 0);

      // Protocol errors: read in IDLE, second start in RUN
      dut_wr = 0;
      drive(0, 0, 1, 9'd7, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(i == 100, 0, 1, 9'(i), 0, 0);
      drain();
      chk("t4_writes", dut_wr, DEPTH);

      // Reset after 100 reads, then a clean stage
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) drive(0, 0, 1, 9'(i), 0, 0);
      do_reset();
      dut_wr = 0;
      for (int i = 0; i < 2 * LAT; i++) idle();
      chk("t5_no_write", dut_wr, 0);
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 9'($urandom), 0, 0);
      drain();
      chk("t5_writes", dut_wr, DEPTH);

      // Short-latency instance: strobe exactly 5 cycles after each read
      drive(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 40; i++) drive(0, 0, 0, 9'(i), 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
